// File: rtl/uart_rx_ctrl_if.sv
// Bundle of the UART receive controller's line, configuration, sampler and result signals.
// err_cnt exists only when UART_RX_ERR_CNT_EN is defined.
interface uart_rx_ctrl_if #(
    parameter int unsigned WIDTH      = 6,
    parameter int unsigned DATA_WIDTH = 8
);
    logic                  RX_IN;
    logic [WIDTH-1:0]      Prescale;
    logic                  PAR_EN;
    logic                  PAR_TYP;
    logic                  sampled_bit;
    logic [WIDTH-1:0]      edge_cnt;
    logic [3:0]            bit_cnt;
    logic                  dat_samp_en;
    logic [DATA_WIDTH-1:0] P_DATA;
    logic                  data_valid;
    logic                  par_err;
    logic                  stop_err;
`ifdef UART_RX_ERR_CNT_EN
    logic [7:0]            err_cnt;

    modport master (
        output RX_IN, Prescale, PAR_EN, PAR_TYP, sampled_bit,
        input  edge_cnt, bit_cnt, dat_samp_en, P_DATA, data_valid, par_err, stop_err, err_cnt
    );
    modport slave (
        input  RX_IN, Prescale, PAR_EN, PAR_TYP, sampled_bit,
        output edge_cnt, bit_cnt, dat_samp_en, P_DATA, data_valid, par_err, stop_err, err_cnt
    );
`else
    modport master (
        output RX_IN, Prescale, PAR_EN, PAR_TYP, sampled_bit,
        input  edge_cnt, bit_cnt, dat_samp_en, P_DATA, data_valid, par_err, stop_err
    );
    modport slave (
        input  RX_IN, Prescale, PAR_EN, PAR_TYP, sampled_bit,
        output edge_cnt, bit_cnt, dat_samp_en, P_DATA, data_valid, par_err, stop_err
    );
`endif
endinterface

// File: rtl/uart_rx_ctrl.sv
// UART receive frame controller: start/data/parity/stop sequencing on oversampled bit decisions.
// Define UART_RX_ERR_CNT_EN to add a saturating 8-bit count of errored frames on err_cnt.
module uart_rx_ctrl #(
    parameter int unsigned WIDTH      = 6,
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic          clk,
    input  logic          RST,
    uart_rx_ctrl_if.slave bus
);
    localparam int unsigned BCW = 4;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t                r_state, w_state_nxt;
    logic [WIDTH-1:0]      r_edge_cnt, w_edge_nxt;
    logic [WIDTH-1:0]      r_presc, w_presc_nxt;
    logic [BCW-1:0]        r_bit_cnt, w_bit_nxt;
    logic [DATA_WIDTH-1:0] r_pdata, w_pdata_nxt;
    logic                  r_dv, w_dv_nxt;
    logic                  r_par_err, w_par_err_nxt;
    logic                  r_stop_err, w_stop_err_nxt;
    logic                  r_par_en, w_par_en_nxt;
    logic                  r_par_typ, w_par_typ_nxt;
    logic                  r_samp_en;
    logic                  w_dp;

    // Decision point: last oversample edge of the current bit
    assign w_dp = (r_edge_cnt == WIDTH'(r_presc - WIDTH'(1)));

    always_comb begin
        w_state_nxt    = r_state;
        w_edge_nxt     = r_edge_cnt;
        w_bit_nxt      = r_bit_cnt;
        w_presc_nxt    = r_presc;
        w_pdata_nxt    = r_pdata;
        w_dv_nxt       = 1'b0;
        w_par_err_nxt  = r_par_err;
        w_stop_err_nxt = r_stop_err;
        w_par_en_nxt   = r_par_en;
        w_par_typ_nxt  = r_par_typ;

        if (r_state != S_IDLE) begin
            w_edge_nxt = w_dp ? '0 : WIDTH'(r_edge_cnt + WIDTH'(1));
            w_bit_nxt  = w_dp ? BCW'(r_bit_cnt + BCW'(1)) : r_bit_cnt;
        end

        case (r_state)
            S_IDLE: begin
                if (!bus.RX_IN) begin
                    w_state_nxt    = S_START;
                    w_edge_nxt     = '0;
                    w_bit_nxt      = '0;
                    w_presc_nxt    = bus.Prescale;
                    w_par_en_nxt   = bus.PAR_EN;
                    w_par_typ_nxt  = bus.PAR_TYP;
                    w_par_err_nxt  = 1'b0;
                    w_stop_err_nxt = 1'b0;
                end
            end
            S_START: begin
                if (w_dp) begin
                    if (bus.sampled_bit) begin
                        w_state_nxt = S_IDLE;
                        w_edge_nxt  = '0;
                        w_bit_nxt   = '0;
                    end else begin
                        w_state_nxt = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (w_dp) begin
                    // LSB arrives first, so each new bit enters at the MSB and shifts right
                    w_pdata_nxt = DATA_WIDTH'({bus.sampled_bit, r_pdata} >> 1);
                    if (r_bit_cnt == BCW'(DATA_WIDTH)) begin
                        w_state_nxt = r_par_en ? S_PARITY : S_STOP;
                    end
                end
            end
            S_PARITY: begin
                if (w_dp) begin
                    if (bus.sampled_bit != ((^r_pdata) ^ r_par_typ)) begin
                        w_par_err_nxt = 1'b1;
                    end
                    w_state_nxt = S_STOP;
                end
            end
            S_STOP: begin
                if (w_dp) begin
                    w_stop_err_nxt = ~bus.sampled_bit;
                    w_dv_nxt       = bus.sampled_bit & ~r_par_err;
                    w_state_nxt    = S_IDLE;
                    w_edge_nxt     = '0;
                    w_bit_nxt      = '0;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_edge_nxt  = '0;
                w_bit_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge RST) begin
        if (!RST) begin
            r_state    <= S_IDLE;
            r_edge_cnt <= '0;
            r_bit_cnt  <= '0;
            r_presc    <= '0;
            r_pdata    <= '0;
            r_dv       <= 1'b0;
            r_par_err  <= 1'b0;
            r_stop_err <= 1'b0;
            r_par_en   <= 1'b0;
            r_par_typ  <= 1'b0;
            r_samp_en  <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_edge_cnt <= w_edge_nxt;
            r_bit_cnt  <= w_bit_nxt;
            r_presc    <= w_presc_nxt;
            r_pdata    <= w_pdata_nxt;
            r_dv       <= w_dv_nxt;
            r_par_err  <= w_par_err_nxt;
            r_stop_err <= w_stop_err_nxt;
            r_par_en   <= w_par_en_nxt;
            r_par_typ  <= w_par_typ_nxt;
            r_samp_en  <= (w_state_nxt != S_IDLE);
        end
    end

`ifdef UART_RX_ERR_CNT_EN
    logic [7:0] r_err_cnt;
    logic       w_frame_err;

    // A frame ends errored at the stop decision if either flag will be set
    assign w_frame_err = (r_state == S_STOP) && w_dp && (!bus.sampled_bit || r_par_err);

    always_ff @(posedge clk or negedge RST) begin
        if (!RST) begin
            r_err_cnt <= 8'd0;
        end else if (w_frame_err && (r_err_cnt != 8'hFF)) begin
            r_err_cnt <= r_err_cnt + 8'd1;
        end
    end

    assign bus.err_cnt = r_err_cnt;
`endif

    assign bus.edge_cnt    = r_edge_cnt;
    assign bus.bit_cnt     = r_bit_cnt;
    assign bus.dat_samp_en = r_samp_en;
    assign bus.P_DATA      = r_pdata;
    assign bus.data_valid  = r_dv;
    assign bus.par_err     = r_par_err;
    assign bus.stop_err    = r_stop_err;
endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Randomized scoreboard bench for uart_rx_ctrl with a mid-bit majority-vote sampler model.
// Honours UART_RX_ERR_CNT_EN for the err_cnt checks.
module tb_uart_rx_ctrl;
    localparam int unsigned WIDTH = 6;
    localparam int unsigned DW    = 8;

    typedef struct {
        logic [7:0] data;
        logic       perr;
        logic       serr;
        logic       dv;
        int         lat;
        int         ecnt;
    } exp_t;

    logic clk = 1'b0;
    logic RST;
    always #5 clk = ~clk;

    uart_rx_ctrl_if #(.WIDTH(WIDTH), .DATA_WIDTH(DW)) bus ();
    uart_rx_ctrl #(.WIDTH(WIDTH), .DATA_WIDTH(DW)) dut (.clk(clk), .RST(RST), .bus(bus));

    exp_t       sb[$];
    exp_t       m_x;
    int         n_chk = 0;
    int         n_fail = 0;
    int         cyc = 0;
    int         start_cyc = 0;
    int         cur_p = 8;
    logic       prev_en = 1'b0;
    logic       v0, v1;
    logic [7:0] m_pdata = 8'd0;
    int         m_ecnt = 0;

    task automatic check(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_edge_cnt"}, int'(bus.edge_cnt), 0);
        check({tag, "_bit_cnt"}, int'(bus.bit_cnt), 0);
        check({tag, "_dat_samp_en"}, int'(bus.dat_samp_en), 0);
        check({tag, "_P_DATA"}, int'(bus.P_DATA), 0);
        check({tag, "_data_valid"}, int'(bus.data_valid), 0);
        check({tag, "_par_err"}, int'(bus.par_err), 0);
        check({tag, "_stop_err"}, int'(bus.stop_err), 0);
`ifdef UART_RX_ERR_CNT_EN
        check({tag, "_err_cnt"}, int'(bus.err_cnt), 0);
`endif
    endtask

    always @(posedge clk) cyc++;

    // Sampler model: three votes around mid-bit, result presented before the decision point
    always @(negedge clk) begin
        if (!RST) begin
            bus.sampled_bit = 1'b1;
        end else if (bus.dat_samp_en) begin
            if (int'(bus.edge_cnt) == cur_p / 2 - 1) v0 = bus.RX_IN;
            else if (int'(bus.edge_cnt) == cur_p / 2) v1 = bus.RX_IN;
            else if (int'(bus.edge_cnt) == cur_p / 2 + 1)
                bus.sampled_bit = (v0 & v1) | (v0 & bus.RX_IN) | (v1 & bus.RX_IN);
        end
    end

    // Monitor: a frame ends when dat_samp_en falls; compare against the oldest expectation
    always @(negedge clk) begin
        if (!RST) begin
            prev_en = 1'b0;
        end else begin
            if (bus.dat_samp_en && !prev_en) start_cyc = cyc;
            if (!bus.dat_samp_en && prev_en) begin
                check("frame_end_expected", int'(sb.size() != 0), 1);
                if (sb.size() != 0) begin
                    m_x = sb.pop_front();
                    check("data_valid", int'(bus.data_valid), int'(m_x.dv));
                    check("par_err", int'(bus.par_err), int'(m_x.perr));
                    check("stop_err", int'(bus.stop_err), int'(m_x.serr));
                    check("P_DATA", int'(bus.P_DATA), int'(m_x.data));
                    check("latency", cyc - start_cyc, m_x.lat);
`ifdef UART_RX_ERR_CNT_EN
                    check("err_cnt", int'(bus.err_cnt), m_x.ecnt);
`endif
                end
            end else begin
                check("data_valid_idle", int'(bus.data_valid), 0);
            end
            prev_en = bus.dat_samp_en;
        end
    end

    task automatic send_frame(input logic [7:0] d, input int p, input logic pen, input logic ptyp,
                              input logic par_ok, input logic stop_b, input int abort_at,
                              input logic twiddle, input int gap);
        logic [11:0] b;
        int          nb;
        logic        pbit;
        exp_t        e;
        b = '0;
        b[0] = 1'b0;
        for (int i = 0; i < 8; i++) b[1 + i] = d[i];
        nb = 9;
        if (pen) begin
            pbit = (^d) ^ ptyp;
            b[nb] = par_ok ? pbit : ~pbit;
            nb++;
        end
        b[nb] = stop_b;
        nb++;
        bus.Prescale = WIDTH'(p);
        bus.PAR_EN   = pen;
        bus.PAR_TYP  = ptyp;
        cur_p        = p;
        if (abort_at < 0) begin
            e.perr = pen && !par_ok;
            e.serr = !stop_b;
            e.dv   = !e.perr && !e.serr;
            m_pdata = d;
            if ((e.perr || e.serr) && m_ecnt < 255) m_ecnt++;
            e.data = m_pdata;
            e.lat  = nb * p;
            e.ecnt = m_ecnt;
            sb.push_back(e);
        end
        for (int i = 0; i < nb; i++) begin
            bus.RX_IN = b[i];
            if (twiddle && i == 3) begin
                bus.Prescale = (p == 8) ? WIDTH'(32) : WIDTH'(8);
                bus.PAR_EN   = ~pen;
                bus.PAR_TYP  = ~ptyp;
            end
            if (i == abort_at) begin
                step(p / 2);
                check("bit_cnt_before_reset", int'(bus.bit_cnt), 4);
                RST = 1'b0;
                #1;
                check_zero("abort");
                m_pdata = 8'd0;
                m_ecnt  = 0;
                step(3);
                bus.RX_IN = 1'b1;
                RST = 1'b1;
                step(2);
                return;
            end
            step((i == nb - 1) ? p + 1 : p);
        end
        if (gap > 0) begin
            bus.RX_IN = 1'b1;
            step(gap);
        end
    endtask

    task automatic send_glitch(input int p);
        exp_t e;
        bus.Prescale = WIDTH'(p);
        cur_p  = p;
        e.data = m_pdata;
        e.perr = 1'b0;
        e.serr = 1'b0;
        e.dv   = 1'b0;
        e.lat  = p;
        e.ecnt = m_ecnt;
        sb.push_back(e);
        bus.RX_IN = 1'b0;
        step(2);
        bus.RX_IN = 1'b1;
        step(p + 4);
    endtask

    initial begin
        int ps[3];
        int k;
        ps[0] = 8; ps[1] = 16; ps[2] = 32;
        RST = 1'b0;
        bus.RX_IN    = 1'b1;
        bus.Prescale = WIDTH'(8);
        bus.PAR_EN   = 1'b0;
        bus.PAR_TYP  = 1'b0;
        step(3);
        check_zero("reset");
        RST = 1'b1;
        step(2);

        send_frame(8'hA5, 8, 1'b0, 1'b0, 1'b1, 1'b1, -1, 1'b0, 2);
        send_frame(8'h3C, 16, 1'b1, 1'b0, 1'b1, 1'b1, -1, 1'b0, 2);
        send_frame(8'h3C, 16, 1'b1, 1'b0, 1'b0, 1'b1, -1, 1'b0, 2);
        send_frame(8'h81, 32, 1'b0, 1'b0, 1'b1, 1'b0, -1, 1'b0, 3);
        send_glitch(8);
        send_frame(8'h55, 8, 1'b0, 1'b0, 1'b1, 1'b1, -1, 1'b0, 0);
        send_frame(8'hAA, 8, 1'b0, 1'b0, 1'b1, 1'b1, -1, 1'b0, 0);
        send_frame(8'hC3, 8, 1'b0, 1'b0, 1'b1, 1'b1, 4, 1'b0, 0);
        send_frame(8'h3E, 8, 1'b0, 1'b0, 1'b1, 1'b1, -1, 1'b0, 2);

        for (int n = 0; n < 24; n++) begin
            if ($urandom_range(0, 7) == 0) begin
                send_glitch(ps[$urandom_range(0, 2)]);
            end else begin
                send_frame(8'($urandom), ps[$urandom_range(0, 2)], 1'($urandom), 1'($urandom),
                           $urandom_range(0, 4) != 0, $urandom_range(0, 6) != 0, -1,
                           $urandom_range(0, 3) == 0, $urandom_range(0, 3));
            end
        end

        bus.RX_IN = 1'b1;
        k = 0;
        while (sb.size() != 0 && k < 2000) begin
            step(1);
            k++;
        end
        check("scoreboard_drained", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule
